// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver with oversampled bit timing and a 4-byte frame assembler
// (ADDR_HI, ADDR_LO, DATA_HI, DATA_LO) producing {rx_addr, rx_data} strobes.
module uart_rx_frame #(
  parameter int unsigned WIDTH_DATA    = 16,
  parameter int unsigned LENGTH_ADDR   = 10,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_en,
  input  logic                   RxD,
  output logic [LENGTH_ADDR-1:0] rx_addr,
  output logic [WIDTH_DATA-1:0]  rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned HI_BITS = LENGTH_ADDR - 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                   state, state_d;
  logic                     rx_meta, rxs;
  logic [TICK_W-1:0]        tick_cnt, tick_d;
  logic [2:0]               bit_cnt, bit_d;
  logic [7:0]               shift, shift_d;
  logic [1:0]               byte_idx, idx_d;
  logic [7:0]               addr_hi, addr_hi_d;
  logic [7:0]               addr_lo, addr_lo_d;
  logic [7:0]               data_hi, data_hi_d;
  logic [TO_W-1:0]          to_cnt, to_d;
  logic [LENGTH_ADDR-1:0]   addr_d;
  logic [WIDTH_DATA-1:0]    data_d;
  logic                     valid_d, err_d, byte_done;

  // Registers: synchroniser, bit engine, frame slots and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_idx  <= '0;
      addr_hi   <= '0;
      addr_lo   <= '0;
      data_hi   <= '0;
      to_cnt    <= '0;
      rx_addr   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_meta   <= RxD;
      rxs       <= rx_meta;
      state     <= state_d;
      tick_cnt  <= tick_d;
      bit_cnt   <= bit_d;
      shift     <= shift_d;
      byte_idx  <= idx_d;
      addr_hi   <= addr_hi_d;
      addr_lo   <= addr_lo_d;
      data_hi   <= data_hi_d;
      to_cnt    <= to_d;
      rx_addr   <= addr_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= err_d;
      rx_busy   <= (state_d != S_IDLE) || (idx_d != 2'd0);
    end
  end

  // Next-state: bit timing, byte acceptance, inter-byte timeout, frame decode
  always_comb begin
    state_d   = state;
    tick_d    = tick_cnt;
    bit_d     = bit_cnt;
    shift_d   = shift;
    idx_d     = byte_idx;
    addr_hi_d = addr_hi;
    addr_lo_d = addr_lo;
    data_hi_d = data_hi;
    to_d      = to_cnt;
    addr_d    = rx_addr;
    data_d    = rx_data;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    byte_done = 1'b0;

    if (rx_en) begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            tick_d  = '0;
            to_d    = '0;
          end else if (byte_idx != 2'd0) begin
            if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
              err_d = 1'b1;
              idx_d = 2'd0;
              to_d  = '0;
            end else begin
              to_d = to_cnt + TO_W'(1);
            end
          end
        end
        S_START: begin
          if (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1)) begin
            tick_d = '0;
            if (!rxs) begin
              state_d = S_DATA;
              bit_d   = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_cnt + TICK_W'(1);
          end
        end
        S_DATA: begin
          if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            shift_d = {rxs, shift[7:1]};
            bit_d   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_d = S_STOP;
          end else begin
            tick_d = tick_cnt + TICK_W'(1);
          end
        end
        S_STOP: begin
          if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            tick_d = '0;
            if (rxs) begin
              state_d   = S_IDLE;
              byte_done = 1'b1;
            end else begin
              state_d = S_WAIT_HIGH;
              err_d   = 1'b1;
              idx_d   = 2'd0;
            end
          end else begin
            tick_d = tick_cnt + TICK_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Accepted byte goes to its slot; the fourth byte completes the frame
    if (byte_done) begin
      idx_d = byte_idx + 2'd1;
      case (byte_idx)
        2'd0: addr_hi_d = shift;
        2'd1: addr_lo_d = shift;
        2'd2: data_hi_d = shift;
        default: begin
          if ((addr_hi >> HI_BITS) == 8'd0) begin
            valid_d = 1'b1;
            addr_d  = LENGTH_ADDR'({addr_hi, addr_lo});
            data_d  = WIDTH_DATA'({data_hi, shift});
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised and directed bench for uart_rx_frame: serial driver, frame-level
// reference model feeding a scoreboard, and an independent output monitor.
module tb_uart_rx_frame;

  localparam int LA = 10;
  localparam int OS = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx_en = 1'b0;
  logic            RxD = 1'b1;
  logic [LA-1:0]   rx_addr;
  logic [15:0]     rx_data;
  logic            rx_valid, frame_err, rx_busy;
  logic [1:0]      div = 2'd0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_valid;
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [9:0]  m_addr = '0;
  logic [15:0] m_data = '0;

  uart_rx_frame dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .RxD(RxD),
    .rx_addr(rx_addr), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Oversample tick every 4 clocks keeps the run short
  always @(posedge clk) begin
    div   <= div + 2'd1;
    rx_en <= (div == 2'd3);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err)) begin
      exp_t e;
      chk("valid_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, rx_valid, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("event_is_valid", 32'(rx_valid), 32'(e.is_valid));
        chk("event_rx_addr", 32'(rx_addr), 32'(e.addr));
        chk("event_rx_data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff rx_en);
    #1;
  endtask

  task automatic send_bit(input logic v);
    RxD = v;
    wait_ticks(OS);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    RxD = 1'b1;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_valid = 1'b0;
    e.addr = m_addr;
    e.data = m_data;
    sb.push_back(e);
  endtask

  // Reference model: legal when ADDR_HI fits in the upper address bits
  task automatic expect_frame(input logic [7:0] b0, b1, b2, b3);
    exp_t e;
    int a;
    a = int'(b0) * 256 + int'(b1);
    if (int'(b0) < (1 << (LA - 8))) begin
      m_addr = 10'(a % (1 << LA));
      m_data = 16'(int'(b2) * 256 + int'(b3));
      e.is_valid = 1'b1;
    end else begin
      e.is_valid = 1'b0;
    end
    e.addr = m_addr;
    e.data = m_data;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, input int max_gap);
    logic [7:0] bytes [4];
    expect_frame(b0, b1, b2, b3);
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      if (max_gap > 0 && i < 3) wait_ticks($urandom_range(0, max_gap));
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() > 0 && k < 400) begin
      wait_ticks(1);
      k++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] b0;
    repeat (6) @(negedge clk);
    chk("reset_rx_addr", 32'(rx_addr), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_rx_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    wait_ticks(20);

    // Basic frame
    send_frame(8'h02, 8'h5A, 8'hBE, 8'hEF, 0);
    drain("t1_drain");
    chk("t1_addr_held", 32'(rx_addr), 32'h25A);
    chk("t1_data_held", 32'(rx_data), 32'hBEEF);

    // Start-bit glitch
    RxD = 1'b0;
    wait_ticks(4);
    chk("t2_busy_during_glitch", 32'(rx_busy), 32'd1);
    RxD = 1'b1;
    wait_ticks(20);
    chk("t2_busy_after_glitch", 32'(rx_busy), 32'd0);

    // Bad stop bit on byte 1, then recovery
    expect_err();
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    wait_ticks(20);
    chk("t3_busy_after_break", 32'(rx_busy), 32'd0);
    send_frame(8'h01, 8'h00, 8'h12, 8'h34, 0);
    drain("t3_drain");

    // Inter-byte timeout: silent before 320 idle ticks, flagged by 408
    send_byte(8'hA1);
    send_byte(8'hB2);
    wait_ticks(305);
    chk("t4_busy_before_timeout", 32'(rx_busy), 32'd1);
    expect_err();
    wait_ticks(95);
    chk("t4_busy_after_timeout", 32'(rx_busy), 32'd0);
    drain("t4_drain_err");
    send_frame(8'h03, 8'h21, 8'hCA, 8'hFE, 0);
    drain("t4_drain");

    // Illegal ADDR_HI
    send_frame(8'h84, 8'h55, 8'h66, 8'h77, 0);
    drain("t5_drain");
    chk("t5_addr_held", 32'(rx_addr), 32'h321);
    chk("t5_data_held", 32'(rx_data), 32'hCAFE);

    // Reset mid-DATA of byte 2, then back-to-back frames
    send_byte(8'h55);
    send_byte(8'h66);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    RxD = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_addr", 32'(rx_addr), 32'd0);
    chk("t6_rst_data", 32'(rx_data), 32'd0);
    chk("t6_rst_busy", 32'(rx_busy), 32'd0);
    chk("t6_rst_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    m_addr = '0;
    m_data = '0;
    wait_ticks(20);
    send_frame(8'h03, 8'hFF, 8'hFF, 8'hFF, 0);
    send_frame(8'h00, 8'h00, 8'h00, 8'h01, 0);
    drain("t6_drain");

    // Randomised frames with random inter-byte gaps
    for (int n = 0; n < 10; n++) begin
      b0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      send_frame(b0, 8'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 1) == 0) ? 0 : 60);
      wait_ticks($urandom_range(0, 10));
    end
    drain("rand_drain");
    chk("final_busy", 32'(rx_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
